// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcode classes,
// opcode values and the ALU operand-B / PC source select codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_ADDI = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_J    = 3'd5
  } op_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUB_B   = 2'd0;
  localparam logic [1:0] ALUB_ONE = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;
  localparam logic [1:0] ALUB_BR  = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode-to-class decode; any opcode outside the supported
// set raises illegal_o (class output is then don't-care, driven as CLS_R).
module mc_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW = 6
) (
  input  logic [OPW-1:0] opcode_i,
  output op_cls_e        cls_o,
  output logic           illegal_o
);

  always_comb begin
    cls_o     = CLS_R;
    illegal_o = 1'b0;
    case (opcode_i)
      OPW'(OP_RTYPE): cls_o = CLS_R;
      OPW'(OP_ADDI):  cls_o = CLS_ADDI;
      OPW'(OP_LW):    cls_o = CLS_LW;
      OPW'(OP_SW):    cls_o = CLS_SW;
      OPW'(OP_BEQ):   cls_o = CLS_BEQ;
      OPW'(OP_J):     cls_o = CLS_J;
      default:        illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with retire counter.
// Build option: define MC_CTRL_RETIRE_CNT_EN to implement the retire counter.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 6,
  parameter int unsigned CNTW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic [1:0]      alu_src_b_sel,
  output logic            alu_src_a_sel,
  output logic [1:0]      pc_src,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ir_we,
  output logic            pc_we,
  output logic            rf_we,
  output logic            rf_dst_rt,
  output logic            mem_to_reg,
  output logic            retire,
  output logic            illegal,
  output logic [CNTW-1:0] retire_cnt
);

  state_e         state_q, state_d;
  logic [OPW-1:0] opcode_q;
  logic [OPW-1:0] dec_op;
  op_cls_e        dec_cls;
  logic           dec_illegal;

  // DECODE looks at the live IR opcode; later states use the copy latched there.
  assign dec_op = (state_q == ST_DECODE) ? opcode : opcode_q;

  mc_op_decode #(.OPW(OPW)) u_dec (
    .opcode_i  (dec_op),
    .cls_o     (dec_cls),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_src_b_sel = ALUB_B;
    alu_src_a_sel = 1'b0;
    pc_src        = PC_ALU;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    rf_we         = 1'b0;
    rf_dst_rt     = 1'b0;
    mem_to_reg    = 1'b0;
    retire        = 1'b0;
    illegal       = 1'b0;
    // Outputs are gated by rst_n so strobes drop the instant reset asserts.
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          if (!halt) begin
            mem_rd        = 1'b1;
            alu_src_b_sel = ALUB_ONE;
            if (mem_ready) begin
              ir_we   = 1'b1;
              pc_we   = 1'b1;
              state_d = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          alu_src_b_sel = ALUB_BR;
          if (dec_illegal) begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_src_a_sel = 1'b1;
          case (dec_cls)
            CLS_R: state_d = ST_WB;
            CLS_ADDI: begin
              alu_src_b_sel = ALUB_IMM;
              state_d       = ST_WB;
            end
            CLS_LW, CLS_SW: begin
              alu_src_b_sel = ALUB_IMM;
              state_d       = ST_MEM;
            end
            CLS_BEQ: begin
              pc_src  = PC_ALUOUT;
              pc_we   = zero;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CLS_J: begin
              pc_src  = PC_JUMP;
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (dec_cls == CLS_LW) mem_rd = 1'b1;
          else                   mem_wr = 1'b1;
          if (mem_ready) begin
            if (dec_cls == CLS_LW) begin
              state_d = ST_WB;
            end else begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
          end
        end
        ST_WB: begin
          rf_we      = 1'b1;
          rf_dst_rt  = (dec_cls == CLS_ADDI) || (dec_cls == CLS_LW);
          mem_to_reg = (dec_cls == CLS_LW);
          retire     = 1'b1;
          state_d    = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNTW'(1);
  end

  assign retire_cnt = cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm, plus hand-written reset-in-MEM
// and counter-wrap sequences.
module tb_mc_ctrl_fsm;

  localparam int unsigned OPW  = 6;
  localparam int unsigned CNTW = 4;

`ifdef MC_CTRL_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Expected output word: {a_sel, b_sel[1:0], pc_src[1:0], mem_rd, mem_wr,
  // ir_we, pc_we, rf_we, rf_dst_rt, mem_to_reg, retire, illegal}
  localparam logic [13:0] X_IDLE = 14'b0_00_00_000000000;
  localparam logic [13:0] X_FWT  = 14'b0_01_00_100000000;
  localparam logic [13:0] X_FET  = 14'b0_01_00_101100000;
  localparam logic [13:0] X_DEC  = 14'b0_11_00_000000000;
  localparam logic [13:0] X_ILL  = 14'b0_11_00_000000001;
  localparam logic [13:0] X_ER   = 14'b1_00_00_000000000;
  localparam logic [13:0] X_EI   = 14'b1_10_00_000000000;
  localparam logic [13:0] X_EB1  = 14'b1_00_01_000100010;
  localparam logic [13:0] X_EB0  = 14'b1_00_01_000000010;
  localparam logic [13:0] X_EJ   = 14'b1_00_10_000100010;
  localparam logic [13:0] X_MLW  = 14'b0_00_00_100000000;
  localparam logic [13:0] X_MSW  = 14'b0_00_00_010000000;
  localparam logic [13:0] X_MSWD = 14'b0_00_00_010000010;
  localparam logic [13:0] X_WR   = 14'b0_00_00_000010010;
  localparam logic [13:0] X_WI   = 14'b0_00_00_000011010;
  localparam logic [13:0] X_WLW  = 14'b0_00_00_000011110;

  typedef struct {
    logic        h;
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [13:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            halt;
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            mem_ready;
  logic [1:0]      alu_src_b_sel;
  logic            alu_src_a_sel;
  logic [1:0]      pc_src;
  logic            mem_rd, mem_wr, ir_we, pc_we, rf_we, rf_dst_rt, mem_to_reg;
  logic            retire, illegal;
  logic [CNTW-1:0] retire_cnt;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned pulses = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.OPW(OPW), .CNTW(CNTW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .halt          (halt),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_src_b_sel (alu_src_b_sel),
    .alu_src_a_sel (alu_src_a_sel),
    .pc_src        (pc_src),
    .mem_rd        (mem_rd),
    .mem_wr        (mem_wr),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .rf_we         (rf_we),
    .rf_dst_rt     (rf_dst_rt),
    .mem_to_reg    (mem_to_reg),
    .retire        (retire),
    .illegal       (illegal),
    .retire_cnt    (retire_cnt)
  );

  function automatic logic [13:0] outs();
    return {alu_src_a_sel, alu_src_b_sel, pc_src, mem_rd, mem_wr, ir_we, pc_we,
            rf_we, rf_dst_rt, mem_to_reg, retire, illegal};
  endfunction

  function automatic void add(input logic h, input logic [5:0] op, input logic z,
                              input logic mr, input logic [13:0] e);
    vec_t v;
    v.h = h; v.op = op; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check_outs(input string nm, input logic [13:0] e);
    logic [13:0] got;
    got = outs();
    nvec++;
    if (got !== e) begin
      nerr++;
      $display("FAIL %s: outputs got %b expected %b", nm, got, e);
    end
    if (retire === 1'b1) pulses++;
  endtask

  task automatic check_cnt(input string nm, input logic [CNTW-1:0] e);
    nvec++;
    if (retire_cnt !== e) begin
      nerr++;
      $display("FAIL %s: retire_cnt got %0d expected %0d", nm, retire_cnt, e);
    end
  endtask

  // Called just after a falling edge: drive, settle, compare, then wait a cycle.
  task automatic drive_chk(input string nm, input logic h, input logic [5:0] op,
                           input logic z, input logic mr, input logic [13:0] e);
    halt = h; opcode = op; zero = z; mem_ready = mr;
    #1;
    check_outs(nm, e);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b1;

    // halted / waiting fetch
    add(1, 6'h00, 0, 1, X_IDLE);
    add(1, 6'h00, 0, 1, X_IDLE);
    add(0, 6'h00, 0, 0, X_FWT);
    // ADD, with the IR opcode changing after DECODE
    add(0, 6'h00, 0, 1, X_FET);
    add(0, 6'h00, 0, 1, X_DEC);
    add(0, 6'h23, 0, 1, X_ER);
    add(0, 6'h23, 0, 1, X_WR);
    // ADDI
    add(0, 6'h08, 0, 1, X_FET);
    add(0, 6'h08, 0, 1, X_DEC);
    add(0, 6'h08, 0, 1, X_EI);
    add(0, 6'h08, 0, 1, X_WI);
    // LW with two MEM wait cycles: 7 cycles total
    add(0, 6'h23, 0, 1, X_FET);
    add(0, 6'h23, 0, 1, X_DEC);
    add(0, 6'h23, 0, 1, X_EI);
    add(0, 6'h23, 0, 0, X_MLW);
    add(0, 6'h23, 0, 0, X_MLW);
    add(0, 6'h23, 0, 1, X_MLW);
    add(0, 6'h23, 0, 1, X_WLW);
    // SW, no wait
    add(0, 6'h2B, 0, 1, X_FET);
    add(0, 6'h2B, 0, 1, X_DEC);
    add(0, 6'h2B, 0, 1, X_EI);
    add(0, 6'h2B, 0, 1, X_MSWD);
    // BEQ taken / not taken
    add(0, 6'h04, 0, 1, X_FET);
    add(0, 6'h04, 0, 1, X_DEC);
    add(0, 6'h04, 1, 1, X_EB1);
    add(0, 6'h04, 0, 1, X_FET);
    add(0, 6'h04, 0, 1, X_DEC);
    add(0, 6'h04, 0, 1, X_EB0);
    // J
    add(0, 6'h02, 0, 1, X_FET);
    add(0, 6'h02, 0, 1, X_DEC);
    add(0, 6'h02, 0, 1, X_EJ);
    // illegal opcode returns to FETCH with no retire
    add(0, 6'h3F, 0, 1, X_FET);
    add(0, 6'h3F, 0, 1, X_ILL);
    // halt mid-instruction does not stall it; it holds the next FETCH
    add(0, 6'h00, 0, 1, X_FET);
    add(1, 6'h00, 0, 1, X_DEC);
    add(1, 6'h00, 0, 1, X_ER);
    add(1, 6'h00, 0, 1, X_WR);
    add(1, 6'h00, 0, 1, X_IDLE);
    add(0, 6'h00, 0, 1, X_FET);
    add(0, 6'h00, 0, 1, X_DEC);
    add(0, 6'h00, 0, 1, X_ER);
    add(0, 6'h00, 0, 1, X_WR);

    // reset state: FETCH with halt=0 would otherwise drive mem_rd
    @(negedge clk);
    #1;
    check_outs("reset_outs", X_IDLE);
    check_cnt("reset_cnt", '0);
    halt = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      drive_chk($sformatf("vec%0d", i), vecs[i].h, vecs[i].op, vecs[i].z,
                vecs[i].mr, vecs[i].exp);
    check_cnt("table_cnt", CNT_EN ? CNTW'(9) : '0);
    check_outs("after_table", X_FET);

    // reset asserted during an SW MEM wait
    drive_chk("sw_f", 0, 6'h2B, 0, 1, X_FET);
    drive_chk("sw_d", 0, 6'h2B, 0, 1, X_DEC);
    drive_chk("sw_e", 0, 6'h2B, 0, 1, X_EI);
    drive_chk("sw_mwait", 0, 6'h2B, 0, 0, X_MSW);
    halt = 1'b0; mem_ready = 1'b0;
    #1;
    check_outs("sw_mwait2", X_MSW);
    rst_n = 1'b0;
    #1;
    check_outs("sw_rst_outs", X_IDLE);
    check_cnt("sw_rst_cnt", '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 17 jumps from a fresh reset; a 4-bit counter wraps to 1
    pulses = 0;
    for (int unsigned k = 0; k < 17; k++) begin
      drive_chk($sformatf("j%0d_f", k), 0, 6'h02, 0, 1, X_FET);
      drive_chk($sformatf("j%0d_d", k), 0, 6'h02, 0, 1, X_DEC);
      drive_chk($sformatf("j%0d_e", k), 0, 6'h02, 0, 1, X_EJ);
    end
    check_cnt("wrap_cnt", CNT_EN ? CNTW'(1) : '0);
    nvec++;
    if (pulses != 17) begin
      nerr++;
      $display("FAIL wrap_pulses: retire pulses got %0d expected 17", pulses);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
